// File: rtl/float_pkg.sv
// Shared definitions for the single-precision subtractor: FSM states,
// overflow status codes, IEEE-754 constants and small datapath helpers.
package float_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_OPER,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  // Status codes reported on the overflow port
  localparam logic [1:0] OVF_NONE    = 2'b00;
  localparam logic [1:0] OVF_OVER    = 2'b01;
  localparam logic [1:0] OVF_UNDER   = 2'b10;
  localparam logic [1:0] OVF_SPECIAL = 2'b11;

  localparam int          BIAS        = 127;
  // All-ones exponent field (255) in the widened 10-bit exponent domain
  localparam logic [9:0]  EXP_MAX     = 10'(2 * BIAS + 1);
  localparam logic [31:0] CANON_NAN   = 32'hFFFF_FFFF;
  // 24-bit significand plus guard, round and sticky
  localparam int          EXT_W       = 27;
  // Beyond this exponent gap the smaller operand only contributes sticky
  localparam logic [9:0]  ALIGN_LIMIT = 10'd26;

  // One-bit right shift that folds the bit falling off into the sticky bit
  function automatic logic [EXT_W-1:0] shr_sticky(input logic [EXT_W-1:0] m);
    return {1'b0, m[EXT_W-1:2], m[1] | m[0]};
  endfunction

  // True for +0 / -0 given the magnitude bits of a single
  function automatic logic is_zero(input logic [30:0] mag);
    return (mag == 31'd0);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand using guard/round/sticky.
// Purely combinational; carry flags a wrap of an all-ones significand.
module fp_round_rne (
  input  logic [23:0] man_in,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  output logic [23:0] man_out,
  output logic        carry
);

  logic round_up;

  // Round up above half an ulp, or exactly at half when the lsb is odd
  assign round_up = g & (r | s | man_in[0]);

  assign {carry, man_out} = {1'b0, man_in} + {24'd0, round_up};

endmodule

// File: rtl/float_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (x - y).
// Sequence: IDLE -> UNPACK -> ALIGN -> OPER -> NORM -> ROUND -> DONE.
// Special operands and zeros skip straight from UNPACK to DONE.
module float_subtractor
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic [1:0]  overflow
);

  state_t           state;
  logic [31:0]      x_reg;
  logic [31:0]      y_reg;
  logic             sign_a;
  logic             sign_b;
  logic [9:0]       exp_a;
  logic [9:0]       exp_b;
  logic [EXT_W-1:0] man_a;
  logic [EXT_W-1:0] man_b;
  logic             res_sign;
  logic [9:0]       res_exp;
  logic [EXT_W:0]   res_man;

  // Operand field decode
  logic [7:0] x_exp;
  logic [7:0] y_exp;
  logic       x_nan;
  logic       y_nan;
  logic       x_inf;
  logic       y_inf;
  logic       x_zero;
  logic       y_zero;

  assign x_exp  = x_reg[30:23];
  assign y_exp  = y_reg[30:23];
  assign x_nan  = (&x_exp) && (|x_reg[22:0]);
  assign y_nan  = (&y_exp) && (|y_reg[22:0]);
  assign x_inf  = (&x_exp) && !(|x_reg[22:0]);
  assign y_inf  = (&y_exp) && !(|y_reg[22:0]);
  assign x_zero = is_zero(x_reg[30:0]);
  assign y_zero = is_zero(y_reg[30:0]);

  // Early-exit results for NaN/Inf and zero operands
  logic        early_exit;
  logic [31:0] early_word;
  logic [1:0]  early_code;

  always_comb begin
    early_exit = 1'b1;
    early_word = 32'd0;
    early_code = OVF_NONE;
    if (x_nan || y_nan) begin
      early_word = CANON_NAN;
      early_code = OVF_SPECIAL;
    end else if (x_inf && y_inf && (x_reg[31] == y_reg[31])) begin
      early_word = CANON_NAN;
      early_code = OVF_SPECIAL;
    end else if (x_inf) begin
      early_word = x_reg;
      early_code = OVF_SPECIAL;
    end else if (y_inf) begin
      early_word = {~y_reg[31], y_reg[30:0]};
      early_code = OVF_SPECIAL;
    end else if (x_zero && y_zero) begin
      early_word = 32'd0;
    end else if (x_zero) begin
      early_word = {~y_reg[31], y_reg[30:0]};
    end else if (y_zero) begin
      early_word = x_reg;
    end else begin
      early_exit = 1'b0;
    end
  end

  // Distance between the two exponents during alignment
  logic [9:0] exp_gap;
  assign exp_gap = (exp_a > exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);

  // Sign-magnitude add/subtract of the aligned extended significands
  logic [EXT_W:0] oper_man;
  logic           oper_sign;

  always_comb begin
    oper_man  = '0;
    oper_sign = sign_a;
    if (sign_a == sign_b) begin
      oper_man = {1'b0, man_a} + {1'b0, man_b};
    end else if (man_a >= man_b) begin
      oper_man = {1'b0, man_a} - {1'b0, man_b};
    end else begin
      oper_man  = {1'b0, man_b} - {1'b0, man_a};
      oper_sign = sign_b;
    end
  end

  // Rounding and final packing
  logic [23:0] rnd_man;
  logic        rnd_carry;
  logic [23:0] round_man;
  logic [9:0]  round_exp;
  logic [31:0] final_word;
  logic [1:0]  final_code;

  fp_round_rne u_round (
    .man_in  (res_man[26:3]),
    .g       (res_man[2]),
    .r       (res_man[1]),
    .s       (res_man[0]),
    .man_out (rnd_man),
    .carry   (rnd_carry)
  );

  assign round_man = rnd_carry ? {1'b1, rnd_man[23:1]} : rnd_man;
  assign round_exp = res_exp + {9'd0, rnd_carry};

  // Classify the rounded value as overflow, denormal or normal
  always_comb begin
    final_word = {res_sign, round_exp[7:0], round_man[22:0]};
    final_code = OVF_NONE;
    if (round_exp >= EXP_MAX) begin
      final_word = {res_sign, 8'hFF, 23'd0};
      final_code = OVF_OVER;
    end else if (!round_man[23]) begin
      final_word = {res_sign, 8'd0, round_man[22:0]};
      final_code = (|round_man[22:0]) ? OVF_UNDER : OVF_NONE;
    end
  end

  // Control FSM and datapath registers; results are latched on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= 32'd0;
      overflow <= OVF_NONE;
      x_reg    <= 32'd0;
      y_reg    <= 32'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      exp_a    <= 10'd0;
      exp_b    <= 10'd0;
      man_a    <= '0;
      man_b    <= '0;
      res_sign <= 1'b0;
      res_exp  <= 10'd0;
      res_man  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg <= x;
            y_reg <= y;
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (early_exit) begin
            diff     <= early_word;
            overflow <= early_code;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            sign_a <= x_reg[31];
            sign_b <= ~y_reg[31];
            exp_a  <= (x_exp == 8'd0) ? 10'd1 : {2'b00, x_exp};
            exp_b  <= (y_exp == 8'd0) ? 10'd1 : {2'b00, y_exp};
            man_a  <= {|x_exp, x_reg[22:0], 3'b000};
            man_b  <= {|y_exp, y_reg[22:0], 3'b000};
            state  <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          if (exp_a == exp_b) begin
            state <= S_OPER;
          end else if (exp_a > exp_b) begin
            if (exp_gap > ALIGN_LIMIT) begin
              man_b <= {{(EXT_W-1){1'b0}}, |man_b};
              exp_b <= exp_a;
            end else begin
              man_b <= shr_sticky(man_b);
              exp_b <= exp_b + 10'd1;
            end
          end else begin
            if (exp_gap > ALIGN_LIMIT) begin
              man_a <= {{(EXT_W-1){1'b0}}, |man_a};
              exp_a <= exp_b;
            end else begin
              man_a <= shr_sticky(man_a);
              exp_a <= exp_a + 10'd1;
            end
          end
        end

        S_OPER: begin
          if (oper_man == '0) begin
            diff     <= 32'd0;
            overflow <= OVF_NONE;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            res_man  <= oper_man;
            res_sign <= oper_sign;
            res_exp  <= exp_a;
            state    <= S_NORM;
          end
        end

        S_NORM: begin
          if (res_man[EXT_W]) begin
            res_man <= {1'b0, res_man[EXT_W:2], res_man[1] | res_man[0]};
            res_exp <= res_exp + 10'd1;
            state   <= S_ROUND;
          end else if (!res_man[EXT_W-1] && (res_exp > 10'd1)) begin
            res_man <= {res_man[EXT_W-1:0], 1'b0};
            res_exp <= res_exp - 10'd1;
          end else begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          diff     <= final_word;
          overflow <= final_code;
          done     <= 1'b1;
          state    <= S_DONE;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
